// File: rtl/acc_cmd_endpoint.sv
// -----------------------------------------------------------------------------
// acc_cmd_endpoint
//
// Accelerator-side endpoint of the manager command protocol. It takes
// execute-task commands off the manager's cmdin stream, forwards the task
// arguments to the kernel, waits for the kernel's done handshake and then
// returns a two-word finished notification (header, task id) on cmdout,
// tagged with this accelerator's ID.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   cmdin_in_*              command words from the manager (tvalid/tready/tdata/tlast)
//   cmdout_out_*            notification words to the manager (tvalid/tready/tid/tdata)
//   arg_out_*               argument words to the kernel (tvalid/tready/tdata/tlast)
//   task_id, task_start     current task id and a one-cycle start pulse
//   done_in_tvalid/tready   kernel finished handshake
//   err_count               saturating count of malformed/unsupported commands
// -----------------------------------------------------------------------------
module acc_cmd_endpoint #(
  parameter int MAX_ACCS = 16,
  parameter int ACC_ID   = 0,
  parameter int MAX_ARGS = 15
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmdin_in_tvalid,
  output logic                        cmdin_in_tready,
  input  logic [63:0]                 cmdin_in_tdata,
  input  logic                        cmdin_in_tlast,
  output logic                        cmdout_out_tvalid,
  input  logic                        cmdout_out_tready,
  output logic [$clog2(MAX_ACCS)-1:0] cmdout_out_tid,
  output logic [63:0]                 cmdout_out_tdata,
  output logic                        arg_out_tvalid,
  input  logic                        arg_out_tready,
  output logic [63:0]                 arg_out_tdata,
  output logic                        arg_out_tlast,
  output logic [63:0]                 task_id,
  output logic                        task_start,
  input  logic                        done_in_tvalid,
  output logic                        done_in_tready,
  output logic [15:0]                 err_count
);

  localparam int          TID_W      = $clog2(MAX_ACCS);
  localparam logic [7:0]  ACC_ID_8   = 8'(ACC_ID);
  localparam logic [7:0]  MAX_ARGS_8 = 8'(MAX_ARGS);
  localparam logic [7:0]  CMD_EXEC   = 8'h01;
  localparam logic [63:0] HDR_WORD   = {40'h0, ACC_ID_8, 8'h00, 8'h03};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_PID,
    ST_RD_TID,
    ST_ARGS,
    ST_DRAIN,
    ST_DRAIN_THEN_WAIT,
    ST_WAIT_DONE,
    ST_SEND_HDR,
    ST_SEND_TID
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_argCnt;
  logic [63:0] r_taskId;
  logic        r_taskStart;
  logic [15:0] r_errCount;

  logic        w_cmdXfer;
  logic        w_errInc;
  logic        w_latchN;
  logic        w_latchTid;
  logic        w_decCnt;
  logic [7:0]  w_hdrCode;
  logic [7:0]  w_hdrN;
  logic        w_hdrOk;

  assign w_hdrCode = cmdin_in_tdata[7:0];
  assign w_hdrN    = cmdin_in_tdata[15:8];
  assign w_hdrOk   = (w_hdrCode == CMD_EXEC) && (w_hdrN <= MAX_ARGS_8);

  assign cmdout_out_tid = TID_W'(ACC_ID);
  assign task_id        = r_taskId;
  assign task_start     = r_taskStart;
  assign err_count      = r_errCount;

  // State register. Reset always lands in IDLE, which silently abandons
  // any task in flight: no done is consumed and no notification goes out.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake outputs and next-state decode. The first case decides which
  // side is allowed to handshake in each state; the second case uses the
  // resulting cmdin transfer to pick the next state and raise the strobes
  // that update the counter, task id and error count. In ARGS the cmdin
  // stream is wired straight through to the kernel so a stalled kernel
  // back-pressures the manager without any buffering here. IDLE's tready
  // is qualified by aresetn so nothing looks ready while reset is held.
  always_comb begin
    w_nextState       = r_state;
    w_errInc          = 1'b0;
    w_latchN          = 1'b0;
    w_latchTid        = 1'b0;
    w_decCnt          = 1'b0;
    cmdin_in_tready   = 1'b0;
    arg_out_tvalid    = 1'b0;
    arg_out_tdata     = '0;
    arg_out_tlast     = 1'b0;
    done_in_tready    = 1'b0;
    cmdout_out_tvalid = 1'b0;
    cmdout_out_tdata  = '0;

    case (r_state)
      ST_IDLE:            cmdin_in_tready = aresetn;
      ST_RD_PID,
      ST_RD_TID,
      ST_DRAIN,
      ST_DRAIN_THEN_WAIT: cmdin_in_tready = 1'b1;
      ST_ARGS: begin
        arg_out_tvalid  = cmdin_in_tvalid;
        cmdin_in_tready = arg_out_tready;
        arg_out_tdata   = cmdin_in_tdata;
        arg_out_tlast   = (r_argCnt == 8'd1) || cmdin_in_tlast;
      end
      ST_WAIT_DONE:       done_in_tready = 1'b1;
      ST_SEND_HDR: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = HDR_WORD;
      end
      ST_SEND_TID: begin
        cmdout_out_tvalid = 1'b1;
        cmdout_out_tdata  = r_taskId;
      end
      default: ;
    endcase

    w_cmdXfer = cmdin_in_tvalid && cmdin_in_tready;

    case (r_state)
      ST_IDLE: begin
        if (w_cmdXfer) begin
          if (w_hdrOk && !cmdin_in_tlast) begin
            w_latchN    = 1'b1;
            w_nextState = ST_RD_PID;
          end else begin
            w_errInc    = 1'b1;
            w_nextState = cmdin_in_tlast ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_RD_PID: begin
        if (w_cmdXfer) begin
          if (cmdin_in_tlast) begin
            w_errInc    = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_RD_TID;
          end
        end
      end
      ST_RD_TID: begin
        if (w_cmdXfer) begin
          w_latchTid = 1'b1;
          if (cmdin_in_tlast && (r_argCnt != 8'd0)) begin
            w_errInc    = 1'b1;
            w_nextState = ST_IDLE;
          end else if (cmdin_in_tlast) begin
            w_nextState = ST_WAIT_DONE;
          end else if (r_argCnt == 8'd0) begin
            w_errInc    = 1'b1;
            w_nextState = ST_DRAIN;
          end else begin
            w_nextState = ST_ARGS;
          end
        end
      end
      ST_ARGS: begin
        if (w_cmdXfer) begin
          w_decCnt = 1'b1;
          if (r_argCnt == 8'd1) begin
            if (cmdin_in_tlast) begin
              w_nextState = ST_WAIT_DONE;
            end else begin
              w_errInc    = 1'b1;
              w_nextState = ST_DRAIN_THEN_WAIT;
            end
          end else if (cmdin_in_tlast) begin
            w_errInc    = 1'b1;
            w_nextState = ST_WAIT_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (w_cmdXfer && cmdin_in_tlast) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_DRAIN_THEN_WAIT: begin
        if (w_cmdXfer && cmdin_in_tlast) begin
          w_nextState = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done_in_tvalid) begin
          w_nextState = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        if (cmdout_out_tready) begin
          w_nextState = ST_SEND_TID;
        end
      end
      ST_SEND_TID: begin
        if (cmdout_out_tready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath registers. The argument counter is loaded with N from the
  // header word and counts down once per forwarded argument, so in ARGS it
  // always holds the number of arguments still owed to the kernel. The
  // task id is captured on the RD_TID transfer and task_start follows one
  // cycle later, so both are visible in the same cycle. The error count
  // sticks at all-ones rather than wrapping back to zero.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_argCnt    <= '0;
      r_taskId    <= '0;
      r_taskStart <= 1'b0;
      r_errCount  <= '0;
    end else begin
      r_taskStart <= w_latchTid;
      if (w_latchN) begin
        r_argCnt <= w_hdrN;
      end else if (w_decCnt) begin
        r_argCnt <= r_argCnt - 8'd1;
      end
      if (w_latchTid) begin
        r_taskId <= cmdin_in_tdata;
      end
      if (w_errInc && (r_errCount != 16'hFFFF)) begin
        r_errCount <= r_errCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_acc_cmd_endpoint.sv
// -----------------------------------------------------------------------------
// tb_acc_cmd_endpoint
//
// Directed bench for acc_cmd_endpoint with ACC_ID=3, MAX_ACCS=16,
// MAX_ARGS=15. Each command is run through a small command-level model that
// predicts the forwarded arguments, task starts, notification words and the
// error count; a negedge monitor compares every DUT transfer against those
// predictions, and a few literal values pin the model to hand-worked results.
// -----------------------------------------------------------------------------
module tb_acc_cmd_endpoint;

  localparam int MAX_ACCS = 16;
  localparam int ACC_ID   = 3;
  localparam int MAX_ARGS = 15;

  logic        aclk;
  logic        aresetn;
  logic        cmdin_in_tvalid;
  logic        cmdin_in_tready;
  logic [63:0] cmdin_in_tdata;
  logic        cmdin_in_tlast;
  logic        cmdout_out_tvalid;
  logic        cmdout_out_tready;
  logic [3:0]  cmdout_out_tid;
  logic [63:0] cmdout_out_tdata;
  logic        arg_out_tvalid;
  logic        arg_out_tready;
  logic [63:0] arg_out_tdata;
  logic        arg_out_tlast;
  logic [63:0] task_id;
  logic        task_start;
  logic        done_in_tvalid;
  logic        done_in_tready;
  logic [15:0] err_count;

  int numCompared   = 0;
  int numMismatched = 0;

  logic [63:0] cmdWords[$];
  logic [63:0] expArgQ[$];
  bit          expArgLastQ[$];
  logic [63:0] expStartQ[$];
  logic [63:0] expOutQ[$];
  int          expErr = 0;

  int          obsArgs     = 0;
  int          obsStarts   = 0;
  int          obsOutCount = 0;
  logic [63:0] obsHdr      = '0;
  logic [63:0] obsTidWord  = '0;
  logic [63:0] obsLastArg  = '0;
  bit          prevHold    = 0;
  bit          argToggle   = 0;

  acc_cmd_endpoint #(
    .MAX_ACCS(MAX_ACCS),
    .ACC_ID  (ACC_ID),
    .MAX_ARGS(MAX_ARGS)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cmdin_in_tvalid  (cmdin_in_tvalid),
    .cmdin_in_tready  (cmdin_in_tready),
    .cmdin_in_tdata   (cmdin_in_tdata),
    .cmdin_in_tlast   (cmdin_in_tlast),
    .cmdout_out_tvalid(cmdout_out_tvalid),
    .cmdout_out_tready(cmdout_out_tready),
    .cmdout_out_tid   (cmdout_out_tid),
    .cmdout_out_tdata (cmdout_out_tdata),
    .arg_out_tvalid   (arg_out_tvalid),
    .arg_out_tready   (arg_out_tready),
    .arg_out_tdata    (arg_out_tdata),
    .arg_out_tlast    (arg_out_tlast),
    .task_id          (task_id),
    .task_start       (task_start),
    .done_in_tvalid   (done_in_tvalid),
    .done_in_tready   (done_in_tready),
    .err_count        (err_count)
  );

  // Free-running 10 ns clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case something upstream of the bounded waits goes wrong.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input string act, input string exp);
    numCompared++;
    numMismatched++;
    $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Kernel-side argument ready: either always ready or toggling every cycle.
  always @(posedge aclk) begin
    #1;
    if (argToggle) arg_out_tready = ~arg_out_tready;
    else           arg_out_tready = 1'b1;
  end

  // Monitor: every transfer the DUT makes on arg_out and cmdout, and every
  // task_start pulse, must match the next item the model predicted. A held
  // cmdout word is re-checked each stalled cycle, and dropping tvalid
  // without a transfer is reported.
  always @(negedge aclk) begin
    if (aresetn !== 1'b1) begin
      prevHold = 0;
    end else begin
      if (arg_out_tvalid && arg_out_tready) begin
        if (expArgQ.size() == 0) begin
          reportFail("arg_unexpected", "transfer", "none");
        end else begin
          checkOutput("arg_tdata", arg_out_tdata, expArgQ[0]);
          checkOutput("arg_tlast", 64'(arg_out_tlast), 64'(expArgLastQ[0]));
          void'(expArgQ.pop_front());
          void'(expArgLastQ.pop_front());
        end
        obsArgs++;
        obsLastArg = arg_out_tdata;
      end
      if (task_start) begin
        if (expStartQ.size() == 0) begin
          reportFail("start_unexpected", "pulse", "none");
        end else begin
          checkOutput("task_id", task_id, expStartQ[0]);
          void'(expStartQ.pop_front());
        end
        obsStarts++;
      end
      if (prevHold && !cmdout_out_tvalid) begin
        reportFail("cmdout_valid_drop", "tvalid=0", "tvalid held until transfer");
      end
      if (cmdout_out_tvalid) begin
        if (expOutQ.size() == 0) begin
          reportFail("cmdout_unexpected", "tvalid=1", "no notification");
        end else begin
          checkOutput("cmdout_tdata", cmdout_out_tdata, expOutQ[0]);
          checkOutput("cmdout_tid", 64'(cmdout_out_tid), 64'(ACC_ID));
          if (cmdout_out_tready) begin
            if (obsOutCount % 2 == 0) obsHdr = cmdout_out_tdata;
            else                      obsTidWord = cmdout_out_tdata;
            obsOutCount++;
            void'(expOutQ.pop_front());
          end
        end
      end
      prevHold = cmdout_out_tvalid && !cmdout_out_tready;
    end
  end

  // Command-level model: decides from the command words alone what the
  // endpoint must do (tlast is always on the final word here).
  task automatic modelCommand(output bit expectDone);
    int len;
    int n;
    int nFwd;
    logic [7:0] code;
    len  = cmdWords.size();
    code = cmdWords[0][7:0];
    n    = int'(cmdWords[0][15:8]);
    expectDone = 0;
    if (code != 8'h01 || n > MAX_ARGS || len < 3) begin
      expErr++;
      return;
    end
    expStartQ.push_back(cmdWords[2]);
    nFwd = (len - 3 < n) ? len - 3 : n;
    if (len - 3 != n) expErr++;
    if ((n == 0 && len > 3) || (n > 0 && len == 3)) return;
    for (int i = 0; i < nFwd; i++) begin
      expArgQ.push_back(cmdWords[3 + i]);
      expArgLastQ.push_back(i == nFwd - 1);
    end
    expOutQ.push_back({40'h0, 8'(ACC_ID), 8'h00, 8'h03});
    expOutQ.push_back(cmdWords[2]);
    expectDone = 1;
  endtask

  task automatic buildExec(input int n, input logic [63:0] tid, input logic [63:0] argBase);
    cmdWords.delete();
    cmdWords.push_back({48'h0, 8'(n), 8'h01});
    cmdWords.push_back(64'h99);
    cmdWords.push_back(tid);
    for (int i = 0; i < n; i++) cmdWords.push_back(argBase + 64'(i));
  endtask

  // One command word; returns once the DUT has accepted it.
  task automatic sendWord(input logic [63:0] d, input logic l);
    int  waited;
    bit  took;
    waited = 0;
    took   = 0;
    cmdin_in_tvalid = 1'b1;
    cmdin_in_tdata  = d;
    cmdin_in_tlast  = l;
    while (!took) begin
      @(negedge aclk);
      took = cmdin_in_tready;
      @(posedge aclk);
      #1;
      waited++;
      if (!took && waited > 200) begin
        reportFail("cmdin_accept_timeout", "no tready", "word accepted");
        break;
      end
    end
    cmdin_in_tvalid = 1'b0;
    cmdin_in_tlast  = 1'b0;
  endtask

  task automatic waitDoneReady(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (done_in_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    if (!ok) reportFail("done_ready_timeout", "tready=0", "tready=1");
  endtask

  // Kernel done handshake, optional cmdout stall, then drain the notification.
  task automatic finishTask(input int stall);
    bit ok;
    bit seen;
    if (stall > 0) cmdout_out_tready = 1'b0;
    waitDoneReady(ok);
    if (!ok) begin
      cmdout_out_tready = 1'b1;
      return;
    end
    done_in_tvalid = 1'b1;
    waitCycles(1);
    done_in_tvalid = 1'b0;
    if (stall > 0) begin
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge aclk);
        if (cmdout_out_tvalid) begin
          seen = 1;
          break;
        end
      end
      if (!seen) reportFail("cmdout_valid_timeout", "tvalid=0", "tvalid=1");
      waitCycles(stall);
      cmdout_out_tready = 1'b1;
    end
    for (int i = 0; i < 50 && expOutQ.size() != 0; i++) @(negedge aclk);
    if (expOutQ.size() != 0) reportFail("cmdout_drain_timeout", "words pending", "notification sent");
    waitCycles(1);
  endtask

  // Run the command in cmdWords end to end against the model.
  task automatic applyStimulus(input int stall);
    bit expectDone;
    modelCommand(expectDone);
    for (int i = 0; i < cmdWords.size(); i++) sendWord(cmdWords[i], i == cmdWords.size() - 1);
    if (expectDone) finishTask(stall);
  endtask

  task automatic endTest(input string name);
    waitCycles(3);
    checkOutput({name, "_err_count"}, 64'(err_count), 64'(expErr));
    checkOutput({name, "_args_left"}, 64'(expArgQ.size()), 64'd0);
    checkOutput({name, "_starts_left"}, 64'(expStartQ.size()), 64'd0);
    checkOutput({name, "_cmdout_left"}, 64'(expOutQ.size()), 64'd0);
  endtask

  task automatic checkResetState();
    @(negedge aclk);
    checkOutput("rst_cmdin_tready", 64'(cmdin_in_tready), 64'd0);
    checkOutput("rst_cmdout_tvalid", 64'(cmdout_out_tvalid), 64'd0);
    checkOutput("rst_cmdout_tdata", cmdout_out_tdata, 64'd0);
    checkOutput("rst_arg_tvalid", 64'(arg_out_tvalid), 64'd0);
    checkOutput("rst_arg_tdata", arg_out_tdata, 64'd0);
    checkOutput("rst_arg_tlast", 64'(arg_out_tlast), 64'd0);
    checkOutput("rst_done_tready", 64'(done_in_tready), 64'd0);
    checkOutput("rst_task_start", 64'(task_start), 64'd0);
    checkOutput("rst_task_id", task_id, 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
  endtask

  // Directed sequence following the test plan, plus a missing-tlast case.
  initial begin
    int argsBefore;
    int startsBefore;
    int outBefore;
    bit ok;
    aresetn           = 1'b0;
    cmdin_in_tvalid   = 1'b0;
    cmdin_in_tdata    = '0;
    cmdin_in_tlast    = 1'b0;
    cmdout_out_tready = 1'b1;
    arg_out_tready    = 1'b1;
    done_in_tvalid    = 1'b0;

    repeat (3) @(posedge aclk);
    checkResetState();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    waitCycles(1);

    $display("[TB] basic execute N=2");
    buildExec(2, 64'h55, 64'hA);
    applyStimulus(0);
    endTest("basic");
    checkOutput("pin_hdr", obsHdr, 64'h0000000000030003);
    checkOutput("pin_tid_word", obsTidWord, 64'h55);
    checkOutput("pin_starts", 64'(obsStarts), 64'd1);
    checkOutput("pin_args", 64'(obsArgs), 64'd2);
    checkOutput("pin_last_arg", obsLastArg, 64'hB);

    $display("[TB] back-pressure on arg_out and cmdout");
    argToggle = 1;
    buildExec(2, 64'h55, 64'hA);
    applyStimulus(5);
    argToggle = 0;
    endTest("stall");
    checkOutput("stall_args", 64'(obsArgs), 64'd4);

    $display("[TB] N=0 command");
    argsBefore = obsArgs;
    buildExec(0, 64'h123, 64'h0);
    applyStimulus(0);
    endTest("n0");
    checkOutput("n0_no_args", 64'(obsArgs - argsBefore), 64'd0);
    checkOutput("n0_tid_word", obsTidWord, 64'h123);

    $display("[TB] unsupported code 0x07");
    startsBefore = obsStarts;
    outBefore    = obsOutCount;
    cmdWords.delete();
    cmdWords.push_back(64'h0007);
    cmdWords.push_back(64'h1);
    cmdWords.push_back(64'h2);
    cmdWords.push_back(64'h3);
    applyStimulus(0);
    endTest("badcode");
    checkOutput("badcode_err_lit", 64'(err_count), 64'd1);
    checkOutput("badcode_no_start", 64'(obsStarts - startsBefore), 64'd0);
    checkOutput("badcode_no_cmdout", 64'(obsOutCount - outBefore), 64'd0);
    buildExec(1, 64'h200, 64'hC);
    applyStimulus(0);
    endTest("after_bad");
    checkOutput("after_bad_tid_word", obsTidWord, 64'h200);

    $display("[TB] N=20 over the argument limit");
    startsBefore = obsStarts;
    cmdWords.delete();
    cmdWords.push_back(64'h1401);
    for (int i = 1; i < 23; i++) cmdWords.push_back(64'h1000 + 64'(i));
    applyStimulus(0);
    endTest("toomany");
    checkOutput("toomany_err_lit", 64'(err_count), 64'd2);
    checkOutput("toomany_no_start", 64'(obsStarts - startsBefore), 64'd0);

    $display("[TB] last argument without tlast");
    buildExec(1, 64'h300, 64'hD);
    cmdWords.push_back(64'hE);
    applyStimulus(0);
    endTest("notlast");
    checkOutput("notlast_err_lit", 64'(err_count), 64'd3);
    checkOutput("notlast_last_arg", obsLastArg, 64'hD);
    checkOutput("notlast_tid_word", obsTidWord, 64'h300);

    $display("[TB] reset during WAIT_DONE");
    outBefore = obsOutCount;
    buildExec(1, 64'h400, 64'hF);
    begin
      bit expectDone;
      modelCommand(expectDone);
    end
    for (int i = 0; i < cmdWords.size(); i++) sendWord(cmdWords[i], i == cmdWords.size() - 1);
    waitDoneReady(ok);
    aresetn = 1'b0;
    expOutQ.delete();
    expErr = 0;
    @(posedge aclk);
    checkResetState();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    waitCycles(5);
    checkOutput("rst_no_cmdout", 64'(obsOutCount - outBefore), 64'd0);
    buildExec(2, 64'h500, 64'h20);
    applyStimulus(0);
    endTest("after_rst");
    checkOutput("after_rst_tid_word", obsTidWord, 64'h500);
    checkOutput("after_rst_last_arg", obsLastArg, 64'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
